// File: rtl/estimate_seq.sv
// rtl/estimate_seq.sv - command sequencer driving a binary-activation estimator over NOUT neurons.
// Optional abort input when ESTIMATE_SEQ_ABORT_EN is defined.
module estimate_seq #(
    parameter int NACC  = 9,
    parameter int NPOOL = 4,
    parameter int NOUT  = 32,
    parameter int WBASE = 0,
    parameter int MBASE = 16960
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef ESTIMATE_SEQ_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy,
    output logic            done,
    output logic [2:0]      com,
    output logic [15:0]     addr,
    output logic [31:0]     data,
    output logic [15:0]     src_addr,
    input  logic [31:0]     src_data,
    input  logic            activ,
    output logic [NOUT-1:0] result,
    output logic            result_valid
);

    localparam int NW = (NOUT > 1) ? $clog2(NOUT) : 1;

    localparam logic [2:0] CMD_INI  = 3'd0;
    localparam logic [2:0] CMD_ACC  = 3'd1;
    localparam logic [2:0] CMD_POOL = 3'd2;
    localparam logic [2:0] CMD_NORM = 3'd3;
    localparam logic [2:0] CMD_ACT  = 3'd4;
    localparam logic [2:0] CMD_NOP  = 3'd7;

    typedef enum logic [2:0] {IDLE, INI, ACC, POOL, NORM, ACT, CAPT, FIN} state_t;

    state_t          state_q, state_d;
    logic [15:0]     k_q, k_d;
    logic [15:0]     p_q, p_d;
    logic [NW-1:0]   n_q, n_d;
    logic [15:0]     nbase_q, nbase_d;
    logic [15:0]     src_q, src_d;
    logic [2:0]      com_q, com_d;
    logic [15:0]     addr_q, addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rv_q, rv_d;
    logic            capt_q, capt_d;
    logic [NW-1:0]   capt_n_q, capt_n_d;
    logic [NOUT-1:0] result_q, result_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            p_q      <= '0;
            n_q      <= '0;
            nbase_q  <= '0;
            src_q    <= '0;
            com_q    <= CMD_NOP;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            capt_q   <= 1'b0;
            capt_n_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            p_q      <= p_d;
            n_q      <= n_d;
            nbase_q  <= nbase_d;
            src_q    <= src_d;
            com_q    <= com_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
            capt_q   <= capt_d;
            capt_n_q <= capt_n_d;
            result_q <= result_d;
        end
    end

    // com/addr are computed from the current state and registered, so they trail it by one cycle.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        p_d      = p_q;
        n_d      = n_q;
        nbase_d  = nbase_q;
        src_d    = src_q;
        com_d    = CMD_NOP;
        addr_d   = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rv_d     = rv_q;
        capt_d   = 1'b0;
        capt_n_d = capt_n_q;
        result_d = result_q;
        if (capt_q) begin
            result_d[capt_n_q] = activ;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INI;
                    busy_d  = 1'b1;
                    rv_d    = 1'b0;
                    n_d     = '0;
                    nbase_d = '0;
                end
            end
            INI: begin
                com_d   = CMD_INI;
                k_d     = '0;
                p_d     = '0;
                src_d   = '0;
                state_d = ACC;
            end
            ACC: begin
                com_d  = CMD_ACC;
                addr_d = 16'(WBASE) + nbase_q + k_q;
                src_d  = src_q + 16'd1;
                if (k_q == 16'(NACC - 1)) begin
                    k_d     = '0;
                    state_d = POOL;
                end else begin
                    k_d = k_q + 16'd1;
                end
            end
            POOL: begin
                com_d = CMD_POOL;
                if (p_q == 16'(NPOOL - 1)) begin
                    state_d = NORM;
                end else begin
                    p_d     = p_q + 16'd1;
                    state_d = ACC;
                end
            end
            NORM: begin
                com_d   = CMD_NORM;
                addr_d  = 16'(MBASE) + 16'(n_q);
                state_d = ACT;
            end
            ACT: begin
                com_d   = CMD_ACT;
                state_d = CAPT;
            end
            CAPT: begin
                // The estimator answers one cycle after com=4, i.e. while this state's NOP is on com.
                capt_d   = 1'b1;
                capt_n_d = n_q;
                if (n_q == NW'(NOUT - 1)) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                end else begin
                    n_d     = n_q + 1'b1;
                    nbase_d = nbase_q + 16'(NACC);
                    state_d = INI;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef ESTIMATE_SEQ_ABORT_EN
        if (abort && state_q != IDLE && state_q != FIN) begin
            state_d = IDLE;
            com_d   = CMD_NOP;
            addr_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            rv_d    = 1'b0;
            capt_d  = 1'b0;
        end
`endif
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign com          = com_q;
    assign addr         = addr_q;
    assign data         = src_data;
    assign src_addr     = (state_q == ACC) ? src_q : 16'd0;
    assign result       = result_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_estimate_seq.sv
// tb/tb_estimate_seq.sv - self-checking bench for estimate_seq against a trace model.
module tb_estimate_seq;
    localparam int NACC  = 9;
    localparam int NPOOL = 4;
    localparam int NOUT  = 32;
    localparam int WBASE = 0;
    localparam int MBASE = 16960;
    localparam int CPN   = 4 + NPOOL * (NACC + 1);
    localparam int L     = NOUT * CPN;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            activ = 1'b0;
    logic [31:0]     src_data = '0;
`ifdef ESTIMATE_SEQ_ABORT_EN
    logic            abort = 1'b0;
`endif
    logic            busy, done, result_valid;
    logic [2:0]      com;
    logic [15:0]     addr, src_addr;
    logic [31:0]     data;
    logic [NOUT-1:0] result;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] key = '0;
    logic [15:0] sa;

    typedef struct {
        logic [2:0]  com;
        logic [15:0] addr;
        logic [15:0] src;
    } ent_t;

    typedef struct {
        logic [31:0] pat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    estimate_seq #(.NACC(NACC), .NPOOL(NPOOL), .NOUT(NOUT), .WBASE(WBASE), .MBASE(MBASE)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef ESTIMATE_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .done(done),
        .com(com),
        .addr(addr),
        .data(data),
        .src_addr(src_addr),
        .src_data(src_data),
        .activ(activ),
        .result(result),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bufword(input logic [15:0] a);
        return {a ^ key[31:16], ~a ^ key[15:0]};
    endfunction

    // Activation buffer: word for the address seen in one cycle is returned in the next.
    always begin
        @(negedge clk);
        sa = src_addr;
        @(posedge clk);
        #1 src_data = bufword(sa);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_run(input logic [31:0] pat, input logic [31:0] exp_res,
                          input bit hold, input int last_c);
        ent_t        q[$];
        ent_t        e;
        int          bad;
        int          ndone;
        string       first;
        logic [2:0]  ecom;
        logic [15:0] eaddr, esrc;
        logic        ebusy, edone, erv;
        for (int n = 0; n < NOUT; n++) begin
            e.com = 3'd0; e.addr = 16'd0; e.src = 16'd0; q.push_back(e);
            for (int p = 0; p < NPOOL; p++) begin
                for (int k = 0; k < NACC; k++) begin
                    e.com = 3'd1; e.addr = 16'(WBASE + n * NACC + k); e.src = 16'(p * NACC + k);
                    q.push_back(e);
                end
                e.com = 3'd2; e.addr = 16'd0; e.src = 16'd0; q.push_back(e);
            end
            e.com = 3'd3; e.addr = 16'(MBASE + n); e.src = 16'd0; q.push_back(e);
            e.com = 3'd4; e.addr = 16'd0; q.push_back(e);
            e.com = 3'd7; q.push_back(e);
        end
        key   = $urandom;
        bad   = 0;
        ndone = 0;
        first = "";
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        if (!hold) begin
            #1 start = 1'b0;
        end
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if (c >= 1 && c - 1 < L) begin
                ecom = q[c-1].com; eaddr = q[c-1].addr;
            end else begin
                ecom = 3'd7; eaddr = 16'd0;
            end
            esrc  = (c < L && q[c].com == 3'd1) ? q[c].src : 16'd0;
            ebusy = (c < L);
            edone = (c == L + 1);
            erv   = (c >= L + 1);
            if (c >= L + 2) begin
                edone = 1'b0;
                if (!hold) begin
                    ebusy = 1'b0; erv = 1'b1;
                end else begin
                    ebusy = 1'b1; erv = 1'b0;
                    if (c == L + 3) ecom = 3'd0;
                end
            end
            if ({com, addr, src_addr, busy, done, result_valid} !==
                {ecom, eaddr, esrc, ebusy, edone, erv}) begin
                if (bad == 0)
                    first = $sformatf("c%0d com/addr/src/busy/done/rv=%0d/%0d/%0d/%0b/%0b/%0b want %0d/%0d/%0d/%0b/%0b/%0b",
                                      c, com, addr, src_addr, busy, done, result_valid,
                                      ecom, eaddr, esrc, ebusy, edone, erv);
                bad++;
            end
            if (ecom == 3'd1 && data !== bufword(q[c-1].src)) begin
                if (bad == 0)
                    first = $sformatf("c%0d data=%0h want %0h", c, data, bufword(q[c-1].src));
                bad++;
            end
            if (ecom == 3'd4) activ = pat[(c - 1) / CPN];
            if (done) ndone++;
        end
        chk($sformatf("trace mismatches %s", first), bad, 0);
        if (last_c >= L + 1) begin
            chk("done pulse count", ndone, 1);
            chk("result", result, exp_res);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0].pat = 32'hAAAAAAAA; vecs[0].exp = 32'hAAAAAAAA;
        vecs[1].pat = 32'h00000000; vecs[1].exp = 32'h00000000;
        vecs[2].pat = 32'hFFFFFFFF; vecs[2].exp = 32'hFFFFFFFF;
        for (int i = 3; i < 5; i++) begin
            vecs[i].pat = $urandom;
            vecs[i].exp = vecs[i].pat;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset com", com, 3'd7);
        chk("reset addr", addr, 16'd0);
        chk("reset src_addr", src_addr, 16'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, '0);
        chk("reset result_valid", result_valid, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("no run without start busy", busy, 1'b0);
        chk("no run without start com", com, 3'd7);

        for (int i = 0; i < 5; i++) begin
            do_run(vecs[i].pat, vecs[i].exp, 1'b0, L + 4);
            chk("result_valid held", result_valid, 1'b1);
        end

        begin
            logic [31:0] r;
            r = $urandom;
            do_run(r, r, 1'b1, L + 3);
        end
        start = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;

        do_run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3 * CPN + 5);
        chk("partial result before reset", result[2:0], 3'b111);
        #1 reset = 1'b1;
        #1;
        chk("async reset com", com, 3'd7);
        chk("async reset busy", busy, 1'b0);
        chk("async reset result", result, '0);
        chk("async reset src_addr", src_addr, 16'd0);
        chk("async reset result_valid", result_valid, 1'b0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;

`ifdef ESTIMATE_SEQ_ABORT_EN
        begin
            int nd;
            nd = 0;
            do_run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2 * CPN + 6);
            abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            @(negedge clk);
            chk("abort busy", busy, 1'b0);
            chk("abort com", com, 3'd7);
            chk("abort result_valid", result_valid, 1'b0);
            chk("abort partial result", result, 32'h3);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk("abort no done", nd, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/estimate_seq.md
ESTIMATE_SEQ -- requirements
Module: estimate_seq

Interface
REQ-001 SHALL have parameter NACC, default 9: acc commands per pooling position.
REQ-002 SHALL have parameter NPOOL, default 4: pooling positions per output neuron.
REQ-003 SHALL have parameter NOUT, default 32: output neurons per run, range 1..256.
REQ-004 SHALL have parameter WBASE, default 0: weight address base.
REQ-005 SHALL have parameter MBASE, default 16960: mean address base.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begin a run.
REQ-009 SHALL have port busy, output, 1 bit: run in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
REQ-011 SHALL have port com, output, 3 bits: command to the estimator (0 ini, 1 acc, 2 pool, 3 norm, 4 activ, 7 no-op).
REQ-012 SHALL have port addr, output, 16 bits: parameter address accompanying com.
REQ-013 SHALL have port data, output, 32 bits: binary activation word accompanying com=1.
REQ-014 SHALL have port src_addr, output, 16 bits: read address to the activation buffer.
REQ-015 SHALL have port src_data, input, 32 bits: buffer read data, valid exactly one cycle after src_addr.
REQ-016 SHALL have port activ, input, 1 bit: estimator result sign bit.
REQ-017 SHALL have port result, output, NOUT bits: captured activ bit per neuron.
REQ-018 SHALL have port result_valid, output, 1 bit: result complete.

Function
REQ-019 SHALL implement FSM states IDLE, INI, ACC, POOL, NORM, ACT, CAPT, FIN.
REQ-020 SHALL register com and addr so each lags the FSM state by one cycle; data SHALL be src_data passed through combinationally, so the word read at src_addr in cycle t appears on data together with com=1 in cycle t+1.
REQ-021 SHALL emit, for neuron n (0..NOUT-1), this com sequence on consecutive cycles with no gaps: one com=0; then, for each p in 0..NPOOL-1, NACC cycles of com=1 followed by one com=2; then one com=3; one com=4; one com=7 (CAPT).
REQ-022 SHALL drive src_addr=p*NACC+k and, one cycle later, addr=WBASE+n*NACC+k on the k-th acc of position p; all 16-bit address sums SHALL wrap modulo 2^16.
REQ-023 SHALL drive addr=MBASE+n with com=3, and addr=0 with com=0, 2, 4 and 7.
REQ-024 SHALL, in the CAPT cycle (the cycle after com=4), load activ into result[n] at the closing rising edge.
REQ-025 SHALL take 4+NPOOL*(NACC+1) cycles per neuron (44 at defaults); neuron n+1 com=0 SHALL directly follow neuron n's CAPT cycle.
REQ-026 SHALL accept start only in IDLE; start asserted while busy SHALL be ignored.
REQ-027 SHALL, when start is sampled at edge E0, drive busy=1 and result_valid=0 from E0, and show com=0 for neuron 0 in the cycle after E0+1.
REQ-028 SHALL, after the last CAPT, enter FIN for one cycle: done=1, result_valid=1, busy=0, com=7; then return to IDLE.
REQ-029 SHALL hold result and result_valid until the next accepted start; start high during FIN SHALL be accepted in the following IDLE cycle.
REQ-030 SHALL drive com=7 in IDLE and FIN, and src_addr=0 whenever no acc is being issued.

Reset
REQ-031 SHALL, on reset assertion at any time including mid-run, immediately force state=IDLE, com=7, addr=0, src_addr=0, busy=0, done=0, result=0 and result_valid=0.
REQ-032 SHALL begin no run before the first start sampled after reset deassertion.

Configuration
REQ-033 SHALL, with ESTIMATE_SEQ_ABORT_EN defined, add input abort (1 bit); abort=1 in any busy state SHALL return the block to IDLE at the next edge with com=7, no done pulse, result_valid=0, and result holding partial contents.
REQ-034 SHALL, without ESTIMATE_SEQ_ABORT_EN, have no abort port and no abort logic.

Verification
REQ-035 SHALL verify: defaults, start pulse -> first com sequence 0, 1x9, 2, 1x9, 2, 1x9, 2, 1x9, 2, 3, 4, 7 with neuron-0 acc addr 0..8 and norm addr 16960.
REQ-036 SHALL verify: neuron 5 -> acc addr 45..53 with src_addr 0..8, 9..17, 18..26, 27..35 one cycle earlier; norm addr 16965.
REQ-037 SHALL verify: activ model returning n%2 -> result=0xAAAAAAAA; done pulses exactly once, 44*32+2 cycles after start edge.
REQ-038 SHALL verify: start held high through a full run -> ignored while busy, second run begins after FIN, result_valid drops at restart.
REQ-039 SHALL verify: reset asserted mid-ACC of neuron 3 -> com=7, busy=0, result=0 without waiting for a clock edge.
REQ-040 SHALL verify: with ESTIMATE_SEQ_ABORT_EN, abort at neuron 2 -> IDLE next edge, no done, result[1:0] retained.
